// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: segment bit positions, the 16 hex glyphs
// (same table the ROM encoder drives) and the scan decoder state type.
package seven_segment_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Index is the hex value; bit0 = a ... bit6 = g, active-high.
   localparam logic [6:0] SEG_PATTERNS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      HOLD
   } scan_state_t;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational inverse of the seven-segment ROM: maps a 7-bit glyph back to
// its hex nibble and flags glyphs that are not in the table.
module seven_segment_pattern_decode
   import seven_segment_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic       o_legal,
   output logic [3:0] o_nibble
);

   logic [6:0] w_segs;

   assign w_segs = {i_seg[SEG_G], i_seg[SEG_F], i_seg[SEG_E], i_seg[SEG_D],
                    i_seg[SEG_C], i_seg[SEG_B], i_seg[SEG_A]};

   always_comb begin
      o_legal  = 1'b0;
      o_nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (w_segs == SEG_PATTERNS[i]) begin
            o_legal  = 1'b1;
            o_nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Watches a multiplexed seven-segment bus, waits for each digit to settle and
// captures the decoded nibble into the slot selected by the one-hot enables.
module seven_segment_scan_decoder
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
)
(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [7:0]              i_seg,
   input  logic [NUM_DIGITS-1:0]   i_an,
   input  logic                    i_err_clr,
   output logic [4*NUM_DIGITS-1:0] o_digits,
   output logic [NUM_DIGITS-1:0]   o_dp_out,
   output logic [NUM_DIGITS-1:0]   o_digit_valid,
   output logic                    o_upd,
   output logic [2:0]              o_upd_idx,
   output logic                    o_frame_valid,
   output logic                    o_err_pattern,
   output logic                    o_err_onehot
);

   localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

   logic [7:0]                  r_sSeg;
   logic [NUM_DIGITS-1:0]       r_sAn;
   logic [CNT_W-1:0]            r_cnt;
   logic [CNT_W-1:0]            w_cntNext;
   logic                        w_changed;
   scan_state_t                 r_state;
   scan_state_t                 w_stateNext;

   logic [NUM_DIGITS-1:0][3:0]  r_digits;
   logic [NUM_DIGITS-1:0]       r_dp;
   logic [NUM_DIGITS-1:0]       r_valid;
   logic [NUM_DIGITS-1:0]       r_seen;
   logic                        r_upd;
   logic [2:0]                  r_updIdx;
   logic                        r_frameValid;
   logic                        r_errPattern;
   logic                        r_errOnehot;

   logic                        w_legal;
   logic [3:0]                  w_nibble;
   logic                        w_oneHot;
   logic [2:0]                  w_idx;
   logic [NUM_DIGITS-1:0]       w_seenMerged;

   // The counter tracks how long the incoming sample has matched the last one.
   always_comb begin
      w_changed = (i_seg != r_sSeg) || (i_an != r_sAn);
      if (w_changed) begin
         w_cntNext = CNT_W'(1);
      end else if (r_cnt >= STABLE_N) begin
         w_cntNext = r_cnt;
      end else begin
         w_cntNext = r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      if (i_an == '0) begin
         w_stateNext = IDLE;
      end else if (w_cntNext < STABLE_N) begin
         w_stateNext = SETTLE;
      end else if (w_changed || r_state == IDLE || r_state == SETTLE) begin
         w_stateNext = CAPTURE;
      end else begin
         w_stateNext = HOLD;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sSeg  <= '0;
         r_sAn   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_sSeg  <= i_seg;
         r_sAn   <= i_an;
      end
   end

   seven_segment_pattern_decode u_decode (
      .i_seg    (r_sSeg[6:0]),
      .o_legal  (w_legal),
      .o_nibble (w_nibble)
   );

   always_comb begin
      w_oneHot     = $onehot(r_sAn);
      w_seenMerged = r_seen | r_sAn;
      w_idx        = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_sAn[i]) begin
            w_idx = 3'(i);
         end
      end
   end

   // A capture writes the slot on the edge that leaves CAPTURE; a new error
   // outranks a simultaneous clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_digits     <= '0;
         r_dp         <= '0;
         r_valid      <= '0;
         r_seen       <= '0;
         r_upd        <= 1'b0;
         r_updIdx     <= 3'd0;
         r_frameValid <= 1'b0;
         r_errPattern <= 1'b0;
         r_errOnehot  <= 1'b0;
      end else begin
         r_upd        <= 1'b0;
         r_frameValid <= 1'b0;
         if (i_err_clr) begin
            r_errPattern <= 1'b0;
            r_errOnehot  <= 1'b0;
         end
         if (r_state == CAPTURE) begin
            if (w_oneHot) begin
               r_upd    <= 1'b1;
               r_updIdx <= w_idx;
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (r_sAn[i]) begin
                     if (w_legal) begin
                        r_digits[i] <= w_nibble;
                        r_dp[i]     <= r_sSeg[SEG_DP];
                        r_valid[i]  <= 1'b1;
                     end else begin
                        r_valid[i]  <= 1'b0;
                     end
                  end
               end
               if (!w_legal) begin
                  r_errPattern <= 1'b1;
               end
               if (&w_seenMerged) begin
                  r_frameValid <= 1'b1;
                  r_seen       <= '0;
               end else begin
                  r_seen       <= w_seenMerged;
               end
            end else begin
               r_errOnehot <= 1'b1;
            end
         end
      end
   end

   assign o_digits      = r_digits;
   assign o_dp_out      = r_dp;
   assign o_digit_valid = r_valid;
   assign o_upd         = r_upd;
   assign o_upd_idx     = r_updIdx;
   assign o_frame_valid = r_frameValid;
   assign o_err_pattern = r_errPattern;
   assign o_err_onehot  = r_errOnehot;

endmodule
